spi_sclk_gen: RTL

//  Programmable SPI serial-clock generator with CPOL/CPHA modes and burst length.
//  It replaces the fixed toggle divider in the SPI master datapath.
//  It produces sclk and bit-accurate sample/shift strobes, which drive the master shift register.

---
 rtl/spi_sclk_gen_if.sv | 27 ++
 rtl/spi_sclk_gen.sv | 120 ++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen_if.sv
// Control and status bundle of the SPI serial-clock generator.
interface spi_sclk_gen_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned NB_W  = 5
);
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic [NB_W-1:0]  nbits;
  logic             cpol;
  logic             cpha;
  logic             sclk;
  logic             sample_stb;
  logic             shift_stb;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, div, nbits, cpol, cpha,
    input  sclk, sample_stb, shift_stb, busy, done
  );

  modport slave (
    input  start, abort, div, nbits, cpol, cpha,
    output sclk, sample_stb, shift_stb, busy, done
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Programmable SPI serial-clock generator: CPOL/CPHA modes, per-transfer
// divider and burst length, registered sclk with sample/shift strobes.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned NB_W  = 5
) (
  input logic           clk,
  input logic           reset,
  spi_sclk_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DIV_W-1:0] r_div_l;
  logic [DIV_W-1:0] r_timer;
  logic [NB_W-1:0]  r_nbits_l;
  logic [NB_W:0]    r_edges;
  logic             r_cpol_l;
  logic             r_cpha_l;
  logic             r_sclk;
  logic             r_sample;
  logic             r_shift;
  logic             r_done;

  logic             w_accept;
  logic             w_tick;
  logic             w_last;
  logic             w_toggle;
  logic [NB_W:0]    w_edge_nxt;

  // Shared decode: accept condition, divider tick and edge bookkeeping.
  always_comb begin
    w_accept   = (r_state == IDLE) && bus.start && !bus.abort && (bus.nbits != '0);
    w_tick     = (r_timer == r_div_l);
    w_last     = (r_edges == {r_nbits_l, 1'b0});
    w_toggle   = (r_state == SETUP) || ((r_state == RUN) && !w_last);
    w_edge_nxt = r_edges + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort from any active state returns to IDLE.
  // After the final edge RUN waits one more half-period with sclk at cpol
  // before HOLD, giving the documented (2*nbits+2)*(div+1) completion time.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = SETUP;
      SETUP: if (bus.abort) w_state_nxt = IDLE;
             else if (w_tick) w_state_nxt = RUN;
      RUN:   if (bus.abort) w_state_nxt = IDLE;
             else if (w_tick && w_last) w_state_nxt = HOLD;
      HOLD:  if (bus.abort || w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latched transfer settings, half-period timer, sclk and strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_l   <= '0;
      r_timer   <= '0;
      r_nbits_l <= '0;
      r_edges   <= '0;
      r_cpol_l  <= 1'b0;
      r_cpha_l  <= 1'b0;
      r_sclk    <= 1'b0;
      r_sample  <= 1'b0;
      r_shift   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_done   <= 1'b0;
      if (r_state == IDLE) begin
        r_sclk  <= bus.cpol;
        r_timer <= '0;
        r_edges <= '0;
        if (w_accept) begin
          r_div_l   <= bus.div;
          r_nbits_l <= bus.nbits;
          r_cpol_l  <= bus.cpol;
          r_cpha_l  <= bus.cpha;
        end
      end else if (bus.abort) begin
        r_sclk <= r_cpol_l;
      end else begin
        r_timer <= w_tick ? '0 : r_timer + 1'b1;
        if (w_tick && w_toggle) begin
          r_sclk   <= ~r_sclk;
          r_edges  <= w_edge_nxt;
          // Odd edge numbers are leading edges.
          r_sample <= w_edge_nxt[0] ^ r_cpha_l;
          r_shift  <= ~(w_edge_nxt[0] ^ r_cpha_l);
        end
        if (w_tick && (r_state == HOLD)) r_done <= 1'b1;
      end
    end
  end

  // Output decode.
  always_comb begin
    bus.sclk       = r_sclk;
    bus.sample_stb = r_sample;
    bus.shift_stb  = r_shift;
    bus.busy       = (r_state != IDLE);
    bus.done       = r_done;
  end

endmodule
